// File: rtl/wb_mem_responder.sv
// Wishbone classic slave backed by a 2^ADDR_W x 16 memory, serving single beats
// and held-strobe line fills with WAIT_N programmable wait cycles per beat.
module wb_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT_N = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [15:0] wb_adr,
    input  logic [1:0]  wb_sel,
    input  logic [15:0] wb_i_dat,
    output logic [15:0] wb_o_dat,
    output logic        wb_ack,
    output logic        wb_err,
    input  logic        i_wp
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_N);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] adr_q;
    logic [15:0] dat_q;
    logic        we_q;
    logic        wp_q;
    logic [1:0]  sel_q;
    logic        ack_q;
    logic        err_q;
    logic [15:0] rdat_q;

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    logic              accept;
    logic              fire;
    logic [15:0]       curAdr;
    logic [15:0]       curDat;
    logic              curWe;
    logic              curWp;
    logic [1:0]        curSel;
    logic              curErr;
    logic [ADDR_W-1:0] curIdx;
    logic              memWe;

    // The beat being completed comes straight from the bus when there are no
    // wait cycles, otherwise from the copy latched at accept.
    always_comb begin
        accept = (state_q == IDLE) && wb_cyc && wb_stb;
        if (state_q == IDLE) begin
            curAdr = wb_adr;
            curDat = wb_i_dat;
            curWe  = wb_we;
            curWp  = i_wp;
            curSel = wb_sel;
        end else begin
            curAdr = adr_q;
            curDat = dat_q;
            curWe  = we_q;
            curWp  = wp_q;
            curSel = sel_q;
        end
        if (WAIT_N == 0) begin
            fire = accept;
        end else begin
            fire = (state_q == WAIT) && wb_cyc && (cnt_q == 4'd1);
        end
        curErr = ((curAdr >> ADDR_W) != 16'h0000) || (curWe && curWp);
        curIdx = curAdr[ADDR_W-1:0];
        memWe  = fire && curWe && !curErr && i_rst_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 16'h0000;
            dat_q   <= 16'h0000;
            we_q    <= 1'b0;
            wp_q    <= 1'b0;
            sel_q   <= 2'b00;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 16'h0000;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (fire) begin
                ack_q <= !curErr;
                err_q <= curErr;
                if (!curErr && !curWe) begin
                    rdat_q <= mem[curIdx];
                end
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        adr_q <= wb_adr;
                        dat_q <= wb_i_dat;
                        we_q  <= wb_we;
                        wp_q  <= i_wp;
                        sel_q <= wb_sel;
                        if (WAIT_N == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_CNT;
                        end
                    end
                end
                WAIT: begin
                    // Losing the cycle aborts; a dropped strobe alone does not.
                    if (!wb_cyc) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory has no reset so its contents survive a bus reset.
    always_ff @(posedge i_clk) begin
        if (memWe) begin
            if (curSel[0]) begin
                mem[curIdx][7:0] <= curDat[7:0];
            end
            if (curSel[1]) begin
                mem[curIdx][15:8] <= curDat[15:8];
            end
        end
    end

    assign wb_o_dat = rdat_q;
    assign wb_ack   = ack_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: one instance with WAIT_N=1, one with WAIT_N=3,
// checked against a scoreboard of expected responses and a shadow memory.
module tb_wb_mem_responder;

    typedef struct {
        logic        isErr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        cyc [2];
    logic        stb [2];
    logic        we [2];
    logic [15:0] adr [2];
    logic [1:0]  sel [2];
    logic [15:0] wdat [2];
    logic        wp [2];
    logic [15:0] odat [2];
    logic        ack [2];
    logic        err [2];

    exp_t        sb [$];
    logic [15:0] model [2][256];
    logic [15:0] lastRead [2];
    int          waitN [2] = '{1, 3};
    int          nCompared = 0;
    int          nMismatched = 0;

    always #5 clk = ~clk;

    wb_mem_responder #(.ADDR_W(8), .WAIT_N(1)) dutA (
        .i_clk(clk), .i_rst_n(rst_n[0]), .wb_cyc(cyc[0]), .wb_stb(stb[0]),
        .wb_we(we[0]), .wb_adr(adr[0]), .wb_sel(sel[0]), .wb_i_dat(wdat[0]),
        .wb_o_dat(odat[0]), .wb_ack(ack[0]), .wb_err(err[0]), .i_wp(wp[0])
    );

    wb_mem_responder #(.ADDR_W(8), .WAIT_N(3)) dutB (
        .i_clk(clk), .i_rst_n(rst_n[1]), .wb_cyc(cyc[1]), .wb_stb(stb[1]),
        .wb_we(we[1]), .wb_adr(adr[1]), .wb_sel(sel[1]), .wb_i_dat(wdat[1]),
        .wb_o_dat(odat[1]), .wb_ack(ack[1]), .wb_err(err[1]), .i_wp(wp[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        assert (obs === expv) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Waits (bounded) for a response, pops the scoreboard and compares it.
    task automatic waitResp(input int d, input string tag, output int n);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[d] || err[d]) seen = 1'b1;
        end
        e = sb.pop_front();
        check({tag, ":seen"}, 32'(seen), 32'd1);
        check({tag, ":err"}, 32'(err[d]), 32'(e.isErr));
        check({tag, ":ack"}, 32'(ack[d]), 32'(!e.isErr));
        check({tag, ":odat"}, 32'(odat[d]), 32'(e.data));
    endtask

    task automatic beat(input int d, input logic w, input logic [15:0] a, input logic [1:0] s,
                        input logic [15:0] v, input logic p, input string tag);
        exp_t       e;
        int         n;
        logic [7:0] idx;
        idx = a[7:0];
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = v; wp[d] = p;
        e.isErr = (a[15:8] != 8'h00) || (w && p);
        if (!e.isErr && w) begin
            if (s[0]) model[d][idx][7:0] = v[7:0];
            if (s[1]) model[d][idx][15:8] = v[15:8];
        end
        if (!e.isErr && !w) lastRead[d] = model[d][idx];
        e.data = lastRead[d];
        sb.push_back(e);
        waitResp(d, tag, n);
        cyc[d] = 1'b0; stb[d] = 1'b0; wp[d] = 1'b0;
        check({tag, ":lat"}, 32'(n), 32'(waitN[d] + 1));
    endtask

    initial begin
        exp_t e;
        int   n;
        int   hits;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = 16'h0000; sel[d] = 2'b00; wdat[d] = 16'h0000; wp[d] = 1'b0;
            lastRead[d] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst:ack", 32'(ack[d]), 32'd0);
            check("rst:err", 32'(err[d]), 32'd0);
            check("rst:odat", 32'(odat[d]), 32'd0);
        end
        // Release just after an edge so the first beat lands on the first edge after release.
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int i = 0; i < 8; i++) begin
            beat(0, 1'b1, 16'h0010 + 16'(i), 2'b11, 16'hA000 + 16'(i), 1'b0, "preload");
        end

        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'h0010; sel[0] = 2'b11;
        for (int i = 0; i < 8; i++) begin
            e.isErr = 1'b0;
            e.data = 16'hA000 + 16'(i);
            lastRead[0] = e.data;
            sb.push_back(e);
            waitResp(0, "burst", n);
            check("burst:gap", 32'(n), (i == 0) ? 32'd2 : 32'd3);
            adr[0] = 16'h0011 + 16'(i);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;

        beat(0, 1'b1, 16'h0005, 2'b11, 16'h1234, 1'b0, "wrFull");
        beat(0, 1'b1, 16'h0005, 2'b10, 16'hFF00, 1'b0, "wrHi");
        beat(0, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "rdLanes");
        check("lanes:value", 32'(odat[0]), 32'h0000FF34);
        beat(0, 1'b1, 16'h0005, 2'b00, 16'hBEEF, 1'b0, "wrSel0");
        beat(0, 1'b1, 16'h0006, 2'b01, 16'h7777, 1'b0, "wrLo");
        beat(0, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "rdSel0");
        beat(0, 1'b0, 16'h0100, 2'b11, 16'h0000, 1'b0, "rdRange");
        beat(0, 1'b1, 16'h0005, 2'b11, 16'h4321, 1'b1, "wrProt");
        beat(0, 1'b1, 16'h8005, 2'b11, 16'h4321, 1'b0, "wrRange");
        beat(0, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "rdAfterErr");
        check("prot:value", 32'(odat[0]), 32'h0000FF34);

        // Reset while the write is waiting: outputs clear at once, the write is lost.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0005; sel[0] = 2'b11; wdat[0] = 16'h9999;
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check("midRst:ack", 32'(ack[0]), 32'd0);
        check("midRst:err", 32'(err[0]), 32'd0);
        check("midRst:odat", 32'(odat[0]), 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        lastRead[0] = 16'h0000;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0] || err[0]) hits++;
        end
        check("midRst:noResp", 32'(hits), 32'd0);
        beat(0, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "rdAfterRst");

        beat(1, 1'b1, 16'h0005, 2'b11, 16'h5555, 1'b0, "bPre");
        beat(1, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "bRd0");
        // Strobe dropped mid-wait must not abort.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0007; sel[1] = 2'b11; wdat[1] = 16'h0707;
        e.isErr = 1'b0; e.data = lastRead[1];
        model[1][8'h07] = 16'h0707;
        sb.push_back(e);
        @(negedge clk);
        stb[1] = 1'b0;
        waitResp(1, "stbDrop", n);
        check("stbDrop:lat", 32'(n), 32'd3);
        cyc[1] = 1'b0;
        // Cycle dropped in the second wait cycle aborts the write.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0005; sel[1] = 2'b11; wdat[1] = 16'h0BAD;
        @(negedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] || err[1]) hits++;
        end
        check("abort:noResp", 32'(hits), 32'd0);
        check("abort:odat", 32'(odat[1]), 32'h00005555);
        beat(1, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, "bRdAbort");
        beat(1, 1'b0, 16'h0007, 2'b11, 16'h0000, 1'b0, "bRdStb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
